// File: rtl/y86_pipe_regs.sv
// rtl/y86_pipe_regs.sv - Y86-64 F/D/E/M/W pipeline register bank with stall/bubble handling
//
// Purpose: holds the five pipeline-stage registers of the Y86-64 pipe. Each stage
// loads its upstream bundle, holds (stall) or loads a NOP bubble as directed by the
// pipeline control logic. Also keeps a sticky control-conflict flag and saturating
// stall/bubble event counters.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   F_stall, D_stall, D_bubble,
//   E_bubble, M_bubble, W_stall     per-stage controls
//   f_predPC, d_in, e_in, m_in, w_in upstream bundles
//   F_predPC, D_out, E_out, M_out,
//   W_out                           registered bundles (same packing as inputs)
//   ctrl_err                        sticky: D_stall and D_bubble seen together
//   stall_cnt, bubble_cnt           saturating event counters
module y86_pipe_regs #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             F_stall,
    input  logic             D_stall,
    input  logic             D_bubble,
    input  logic             E_bubble,
    input  logic             M_bubble,
    input  logic             W_stall,
    input  logic [63:0]      f_predPC,
    input  logic [146:0]     d_in,
    input  logic [218:0]     e_in,
    input  logic [143:0]     m_in,
    input  logic [142:0]     w_in,
    output logic [63:0]      F_predPC,
    output logic [146:0]     D_out,
    output logic [218:0]     E_out,
    output logic [143:0]     M_out,
    output logic [142:0]     W_out,
    output logic             ctrl_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [2:0] SBUB  = 3'h0;
    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [3:0] RNONE = 4'hF;

    // Bubble images: stat=SBUB, icode=INOP, register ids=RNONE, everything else 0.
    localparam logic [146:0] D_BUBBLE = {SBUB, INOP, 4'h0, RNONE, RNONE, 64'h0, 64'h0};
    localparam logic [218:0] E_BUBBLE = {SBUB, INOP, 4'h0, 64'h0, 64'h0, 64'h0,
                                         RNONE, RNONE, RNONE, RNONE};
    localparam logic [143:0] M_BUBBLE = {SBUB, INOP, 1'b0, 64'h0, 64'h0, RNONE, RNONE};
    localparam logic [142:0] W_BUBBLE = {SBUB, INOP, 64'h0, 64'h0, RNONE, RNONE};

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [63:0]      f_pc_q,     f_pc_d;
    logic [146:0]     d_q,        d_d;
    logic [218:0]     e_q,        e_d;
    logic [143:0]     m_q,        m_d;
    logic [142:0]     w_q,        w_d;
    logic             err_q,      err_d;
    logic [CNT_W-1:0] stall_q,    stall_d;
    logic [CNT_W-1:0] bubble_q,   bubble_d;

    logic any_bubble;

    assign any_bubble = D_bubble | E_bubble | M_bubble;

    always_comb begin
        f_pc_d   = f_pc_q;
        d_d      = d_q;
        e_d      = e_in;
        m_d      = m_in;
        w_d      = w_q;
        err_d    = err_q;
        stall_d  = stall_q;
        bubble_d = bubble_q;

        if (!F_stall) begin
            f_pc_d = f_predPC;
        end

        // Stall has priority over bubble on D; the combination is flagged below.
        if (!D_stall) begin
            d_d = D_bubble ? D_BUBBLE : d_in;
        end

        if (E_bubble) begin
            e_d = E_BUBBLE;
        end

        if (M_bubble) begin
            m_d = M_BUBBLE;
        end

        if (!W_stall) begin
            w_d = w_in;
        end

        if (D_stall && D_bubble) begin
            err_d = 1'b1;
        end

        // Counters stick at all-ones rather than wrapping.
        if (F_stall && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end

        if (any_bubble && (bubble_q != CNT_MAX)) begin
            bubble_d = bubble_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc_q   <= RESET_PC;
            d_q      <= D_BUBBLE;
            e_q      <= E_BUBBLE;
            m_q      <= M_BUBBLE;
            w_q      <= W_BUBBLE;
            err_q    <= 1'b0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            f_pc_q   <= f_pc_d;
            d_q      <= d_d;
            e_q      <= e_d;
            m_q      <= m_d;
            w_q      <= w_d;
            err_q    <= err_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign F_predPC   = f_pc_q;
    assign D_out      = d_q;
    assign E_out      = e_q;
    assign M_out      = m_q;
    assign W_out      = w_q;
    assign ctrl_err   = err_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: doc/y86_pipe_regs.md
Name: y86_pipe_regs

Overview:
- Pipeline register bank (F, D, E, M, W) for the Y86-64 five-stage pipe; consumes the stall/bubble controls from the pipeline control logic.
- Each stage register either loads its upstream bundle, holds (stall) or loads a NOP bubble.
- Also keeps a sticky control-conflict flag and stall/bubble event counters for debug and perf.

Parameters:
- RESET_PC, 64'h0, predPC value loaded on reset.
- CNT_W, 32, width of the event counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  in  1 each  stage controls.
- f_predPC  in  64  next predicted PC from fetch.
- d_in  in  147  fetch->D bundle: stat[146:144] icode[143:140] ifun[139:136] rA[135:132] rB[131:128] valC[127:64] valP[63:0].
- e_in  in  219  decode->E bundle: stat[218:216] icode[215:212] ifun[211:208] valC[207:144] valA[143:80] valB[79:16] dstE[15:12] dstM[11:8] srcA[7:4] srcB[3:0].
- m_in  in  144  execute->M bundle: stat[143:141] icode[140:137] Cnd[136] valE[135:72] valA[71:8] dstE[7:4] dstM[3:0].
- w_in  in  143  memory->W bundle: stat[142:140] icode[139:136] valE[135:72] valM[71:8] dstE[7:4] dstM[3:0].
- F_predPC  out  64  registered predPC.
- D_out, E_out, M_out, W_out  out  147/219/144/143  registered bundles, same packing as inputs.
- ctrl_err  out  1  sticky: stall and bubble both asserted on one stage.
- stall_cnt  out  CNT_W  count of cycles with F_stall=1.
- bubble_cnt  out  CNT_W  count of cycles with any of D_bubble, E_bubble, M_bubble =1.

Behaviour:
- Encodings: SBUB=3'h0, SAOK=3'h1, SHLT=3'h2, SADR=3'h3, SINS=3'h4; INOP=4'h1; RNONE=4'hF.
- Bubble value per stage: stat=SBUB, icode=INOP, ifun=0, every reg-id field=RNONE, every data field=0, Cnd=0.
- Reset (sync, high): F_predPC=RESET_PC; D/E/M/W load bubble values; ctrl_err=0; counters=0. Reset overrides every control input, including mid-stall.
- F: F_stall=1 -> hold; else load f_predPC.
- D: D_stall=1 -> hold; else D_bubble=1 -> bubble; else load d_in.
- E: E_bubble=1 -> bubble; else load e_in.
- M: M_bubble=1 -> bubble; else load m_in.
- W: W_stall=1 -> hold; else load w_in.
- Latency: exactly 1 cycle from input to output for every stage. Outputs come straight from the registers, with no combinational path from inputs.
- Conflict rule: if D_stall and D_bubble are both 1, stall wins (D holds) and ctrl_err sets on that edge. ctrl_err stays set until reset. F, E, M and W have no conflict case.
- Counters: increment by 1 on each qualifying edge. They saturate at all-ones and never wrap. A cycle with multiple bubbles increments bubble_cnt by 1 only.
- Simultaneous: reset plus any control -> reset behaviour, counters cleared, no increment that cycle.

Test Plan:
- Reset, then 1 idle cycle with all controls 0 and d_in stat=SAOK icode=4'h3 -> F_predPC=RESET_PC before the first load. D_out holds bubble (stat=0, icode=1, rA=rB=F) until the first load, then shows icode=3 one cycle later.
- Load-use: F_stall=D_stall=E_bubble=1 for 1 cycle with D_out holding icode=4'h6 -> F_predPC and D_out unchanged, E_out=bubble, stall_cnt=1, bubble_cnt=1.
- Mispredict: E_bubble=D_bubble=1, d_in icode=4'h2 -> D_out and E_out both bubble next cycle, bubble_cnt +1 only.
- Exception: M_bubble=W_stall=1 for 3 cycles with W_out stat=SADR -> W_out constant over all 3 cycles, M_out=bubble, bubble_cnt +3.
- Conflict: D_stall=D_bubble=1 -> D_out holds, ctrl_err=1 and stays 1 after controls drop. Reset clears it.
- Saturation with CNT_W=4: hold F_stall=1 for 20 cycles -> stall_cnt reaches 4'hF and stays there. A reset asserted during the stall -> stall_cnt=0 and F_predPC=RESET_PC next cycle.
